// File: rtl/eth_pcs_rx_descrambler_if.sv
// Beat-in / block-out bundle between the RX gearbox, the descrambler and the 64b/66b decoder.
// slave = descrambler side, master = gearbox/decoder side (or a testbench).
interface eth_pcs_rx_descrambler_if #(
  parameter int W_DATA = 32,
  parameter int W_SYNC = 2
);
  logic                  i_rx_lock;
  logic                  i_hdr_valid;
  logic [W_SYNC-1:0]     i_hdr;
  logic                  i_data_valid;
  logic [W_DATA-1:0]     i_data;
  logic                  o_blk_valid;
  logic [W_SYNC-1:0]     o_blk_hdr;
  logic [2*W_DATA-1:0]   o_blk_data;
  logic                  o_blk_hdr_err;
  logic                  o_hi_ber;

  modport slave (
    input  i_rx_lock, i_hdr_valid, i_hdr, i_data_valid, i_data,
    output o_blk_valid, o_blk_hdr, o_blk_data, o_blk_hdr_err, o_hi_ber
  );

  modport master (
    output i_rx_lock, i_hdr_valid, i_hdr, i_data_valid, i_data,
    input  o_blk_valid, o_blk_hdr, o_blk_data, o_blk_hdr_err, o_hi_ber
  );
endinterface

// File: rtl/eth_pcs_rx_descrambler.sv
// 10GBASE-R RX: pairs 32b gearbox beats into 66b blocks and self-sync descrambles them (1+x^39+x^58).
// Define ETH_PCS_RX_BER_MON_EN to build the hi_ber monitor; otherwise o_hi_ber is tied low.
module eth_pcs_rx_descrambler #(
  parameter int W_DATA       = 32,
  parameter int W_SYNC       = 2,
  parameter int BER_WIN_BLKS = 19531,
  parameter int BER_THRESH   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  eth_pcs_rx_descrambler_if.slave bus
);

  localparam int W_STATE = 58;
  localparam int TAP_A   = 39;

  generate
    if (W_DATA != 32 || W_SYNC != 2 || BER_WIN_BLKS < 2 || BER_THRESH < 1) begin : g_cfg_err
      $error("eth_pcs_rx_descrambler: unsupported parameter set");
    end
  endgenerate

  typedef enum logic {HALF_FIRST, HALF_SECOND} half_e;

  half_e                 half_q, half_d;
  logic [W_STATE-1:0]    scr_q, scr_d;
  logic [W_SYNC-1:0]     hdr_q, hdr_d;
  logic [W_DATA-1:0]     low_q, low_d;
  logic                  blk_valid_q, blk_valid_d;
  logic [W_SYNC-1:0]     blk_hdr_q, blk_hdr_d;
  logic [2*W_DATA-1:0]   blk_data_q, blk_data_d;
  logic                  blk_err_q, blk_err_d;

  // hist[k]: oldest received bit at k=0, newest beat bit 31 at the top
  logic [W_STATE+W_DATA-1:0] hist;
  logic [W_DATA-1:0]         desc;

  assign hist = {bus.i_data, scr_q};

  generate
    for (genvar gi = 0; gi < W_DATA; gi++) begin : g_desc
      assign desc[gi] = hist[W_STATE+gi] ^ hist[W_STATE-TAP_A+gi] ^ hist[gi];
    end
  endgenerate

  assign scr_d = bus.i_data_valid ? hist[W_STATE+W_DATA-1:W_DATA] : scr_q;

  always_comb begin
    half_d      = half_q;
    hdr_d       = hdr_q;
    low_d       = low_q;
    blk_valid_d = 1'b0;
    blk_hdr_d   = blk_hdr_q;
    blk_data_d  = blk_data_q;
    blk_err_d   = blk_err_q;
    if (!bus.i_rx_lock) begin
      half_d = HALF_FIRST;
    end else if (bus.i_data_valid) begin
      case (half_q)
        HALF_FIRST: begin
          if (bus.i_hdr_valid) begin
            hdr_d  = bus.i_hdr;
            low_d  = desc;
            half_d = HALF_SECOND;
          end
        end
        HALF_SECOND: begin
          if (bus.i_hdr_valid) begin
            // resync: the new header restarts the block, previous low half is lost
            hdr_d = bus.i_hdr;
            low_d = desc;
          end else begin
            blk_valid_d = 1'b1;
            blk_hdr_d   = hdr_q;
            blk_data_d  = {desc, low_q};
            blk_err_d   = (hdr_q == '0) || (hdr_q == '1);
            half_d      = HALF_FIRST;
          end
        end
        default: half_d = HALF_FIRST;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      half_q      <= HALF_FIRST;
      scr_q       <= '0;
      hdr_q       <= '0;
      low_q       <= '0;
      blk_valid_q <= 1'b0;
      blk_hdr_q   <= '0;
      blk_data_q  <= '0;
      blk_err_q   <= 1'b0;
    end else begin
      half_q      <= half_d;
      scr_q       <= scr_d;
      hdr_q       <= hdr_d;
      low_q       <= low_d;
      blk_valid_q <= blk_valid_d;
      blk_hdr_q   <= blk_hdr_d;
      blk_data_q  <= blk_data_d;
      blk_err_q   <= blk_err_d;
    end
  end

  assign bus.o_blk_valid   = blk_valid_q;
  assign bus.o_blk_hdr     = blk_hdr_q;
  assign bus.o_blk_data    = blk_data_q;
  assign bus.o_blk_hdr_err = blk_err_q;

`ifdef ETH_PCS_RX_BER_MON_EN
  localparam int W_BLK_CNT = $clog2(BER_WIN_BLKS);
  localparam int W_ERR_CNT = $clog2(BER_THRESH + 1);
  localparam logic [W_BLK_CNT-1:0] BLK_LAST = W_BLK_CNT'(BER_WIN_BLKS - 1);
  localparam logic [W_ERR_CNT-1:0] ERR_MAX  = W_ERR_CNT'(BER_THRESH);

  logic [W_BLK_CNT-1:0] blk_cnt_q, blk_cnt_d;
  logic [W_ERR_CNT-1:0] err_cnt_q, err_cnt_d;
  logic                 hi_ber_q, hi_ber_d;

  // Counts the block presented on the outputs; a bad header on the wrap block opens the new window.
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    err_cnt_d = err_cnt_q;
    hi_ber_d  = hi_ber_q;
    if (!bus.i_rx_lock) begin
      blk_cnt_d = '0;
      err_cnt_d = '0;
      hi_ber_d  = 1'b0;
    end else if (blk_valid_q) begin
      if (blk_cnt_q == BLK_LAST) begin
        blk_cnt_d = '0;
        err_cnt_d = blk_err_q ? W_ERR_CNT'(1) : '0;
        if (err_cnt_q < ERR_MAX) begin
          hi_ber_d = 1'b0;
        end
      end else begin
        blk_cnt_d = blk_cnt_q + 1'b1;
        if (blk_err_q && (err_cnt_q != ERR_MAX)) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
      end
      if (blk_err_q && (err_cnt_d == ERR_MAX)) begin
        hi_ber_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      blk_cnt_q <= '0;
      err_cnt_q <= '0;
      hi_ber_q  <= 1'b0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      err_cnt_q <= err_cnt_d;
      hi_ber_q  <= hi_ber_d;
    end
  end

  assign bus.o_hi_ber = hi_ber_q;
`else
  assign bus.o_hi_ber = 1'b0;
`endif

endmodule

// File: tb/tb_eth_pcs_rx_descrambler.sv
// Self-checking bench for eth_pcs_rx_descrambler: framing table, known-answer, reset, BER and random traffic
// against a bit-serial reference model. Define ETH_PCS_RX_BER_MON_EN to exercise the BER monitor.
module tb_eth_pcs_rx_descrambler;

  localparam int WIN = 64;
  localparam int THR = 16;
`ifdef ETH_PCS_RX_BER_MON_EN
  localparam bit BER_ON = 1'b1;
`else
  localparam bit BER_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_pcs_rx_descrambler_if #(.W_DATA(32), .W_SYNC(2)) bus ();

  eth_pcs_rx_descrambler #(
    .W_DATA(32), .W_SYNC(2), .BER_WIN_BLKS(WIN), .BER_THRESH(THR)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          rx_hist[$];
  bit          tx_hist[$];
  bit          m_have_low;
  logic [1:0]  m_hdr;
  logic [31:0] m_low;
  logic [1:0]  e_hdr;
  logic [63:0] e_data;
  logic        e_err;
  bit          b_hi;
`ifdef ETH_PCS_RX_BER_MON_EN
  bit          prev_valid;
  bit          prev_err;
  int          blk_total;
  int          win_err[int];
`endif

  typedef struct {
    bit         lock;
    bit         hv;
    logic [1:0] hdr;
    bit         dv;
    bit         exp_v;
    logic [1:0] exp_hdr;
    bit         exp_err;
  } vec_t;
  vec_t tbl[23];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    rx_hist.delete();
    for (int i = 0; i < 58; i++) rx_hist.push_back(1'b0);
    m_have_low = 1'b0;
    m_hdr      = '0;
    m_low      = '0;
    e_hdr      = '0;
    e_data     = '0;
    e_err      = 1'b0;
    b_hi       = 1'b0;
`ifdef ETH_PCS_RX_BER_MON_EN
    prev_valid = 1'b0;
    prev_err   = 1'b0;
    blk_total  = 0;
    win_err.delete();
`endif
  endtask

  // rx_hist[0] is r(n-58), rx_hist[19] is r(n-39)
  task automatic model_descramble(input logic [31:0] r, output logic [31:0] d);
    for (int i = 0; i < 32; i++) begin
      d[i] = r[i] ^ rx_hist[19] ^ rx_hist[0];
      rx_hist.push_back(r[i]);
      void'(rx_hist.pop_front());
    end
  endtask

  task automatic scramble64(input logic [63:0] d, output logic [63:0] s);
    for (int i = 0; i < 64; i++) begin
      s[i] = d[i] ^ tx_hist[19] ^ tx_hist[0];
      tx_hist.push_back(s[i]);
      void'(tx_hist.pop_front());
    end
  endtask

  // One clock: drive a beat, let the edge take it, then compare against the model 1 time unit later.
  task automatic step(input bit lock, input bit hv, input logic [1:0] hdr, input bit dv,
                      input logic [31:0] data);
    logic [31:0] d;
    bit ev;
    bus.i_rx_lock    = lock;
    bus.i_hdr_valid  = hv;
    bus.i_hdr        = hdr;
    bus.i_data_valid = dv;
    bus.i_data       = data;
    @(posedge clk);
    #1;
`ifdef ETH_PCS_RX_BER_MON_EN
    if (!lock) begin
      blk_total = 0;
      win_err.delete();
      b_hi = 1'b0;
    end else if (prev_valid) begin
      int j;
      int w_new;
      j = blk_total;
      w_new = (j + 1) / WIN;
      if ((j % WIN) == WIN - 1) begin
        if (!(win_err.exists(j / WIN) && win_err[j / WIN] >= THR)) b_hi = 1'b0;
      end
      if (prev_err) begin
        win_err[w_new] = (win_err.exists(w_new) ? win_err[w_new] : 0) + 1;
        if (win_err[w_new] >= THR) b_hi = 1'b1;
      end
      blk_total++;
    end
`endif
    d = '0;
    if (dv) model_descramble(data, d);
    ev = 1'b0;
    if (!lock) begin
      m_have_low = 1'b0;
    end else if (dv) begin
      if (hv) begin
        m_have_low = 1'b1;
        m_hdr = hdr;
        m_low = d;
      end else if (m_have_low) begin
        ev = 1'b1;
        m_have_low = 1'b0;
        e_hdr  = m_hdr;
        e_data = {d, m_low};
        e_err  = (m_hdr == 2'b00) || (m_hdr == 2'b11);
      end
    end
`ifdef ETH_PCS_RX_BER_MON_EN
    prev_valid = ev;
    prev_err   = e_err;
`endif
    check("blk_valid", 64'(bus.o_blk_valid), 64'(ev));
    check("blk_hdr", 64'(bus.o_blk_hdr), 64'(e_hdr));
    check("blk_data", bus.o_blk_data, e_data);
    check("blk_hdr_err", 64'(bus.o_blk_hdr_err), 64'(e_err));
    check("hi_ber", 64'(bus.o_hi_ber), 64'(b_hi));
  endtask

  task automatic send_block(input logic [1:0] hdr);
    step(1'b1, 1'b1, hdr, 1'b1, $urandom);
    step(1'b1, 1'b0, 2'b00, 1'b1, $urandom);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_valid", 64'(bus.o_blk_valid), 64'd0);
    check("rst_hdr", 64'(bus.o_blk_hdr), 64'd0);
    check("rst_data", bus.o_blk_data, 64'd0);
    check("rst_hdr_err", 64'(bus.o_blk_hdr_err), 64'd0);
    check("rst_hi_ber", 64'(bus.o_hi_ber), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] p;
    logic [1:0]  h;

    tbl[0]  = '{1, 1, 2'b01, 1, 0, 2'b00, 0};
    tbl[1]  = '{1, 0, 2'b00, 1, 1, 2'b01, 0};
    tbl[2]  = '{1, 0, 2'b00, 1, 0, 2'b00, 0};
    tbl[3]  = '{1, 1, 2'b11, 0, 0, 2'b00, 0};
    tbl[4]  = '{1, 0, 2'b00, 1, 0, 2'b00, 0};
    tbl[5]  = '{1, 1, 2'b11, 1, 0, 2'b00, 0};
    tbl[6]  = '{1, 0, 2'b00, 0, 0, 2'b00, 0};
    tbl[7]  = '{1, 0, 2'b00, 1, 1, 2'b11, 1};
    tbl[8]  = '{1, 1, 2'b01, 1, 0, 2'b00, 0};
    tbl[9]  = '{1, 1, 2'b10, 1, 0, 2'b00, 0};
    tbl[10] = '{1, 0, 2'b00, 1, 1, 2'b10, 0};
    tbl[11] = '{1, 1, 2'b00, 1, 0, 2'b00, 0};
    tbl[12] = '{0, 0, 2'b00, 1, 0, 2'b00, 0};
    tbl[13] = '{1, 0, 2'b00, 1, 0, 2'b00, 0};
    tbl[14] = '{1, 1, 2'b00, 1, 0, 2'b00, 0};
    tbl[15] = '{1, 0, 2'b00, 1, 1, 2'b00, 1};
    tbl[16] = '{1, 1, 2'b01, 1, 0, 2'b00, 0};
    tbl[17] = '{0, 0, 2'b00, 0, 0, 2'b00, 0};
    tbl[18] = '{1, 0, 2'b00, 1, 0, 2'b00, 0};
    tbl[19] = '{0, 1, 2'b10, 1, 0, 2'b00, 0};
    tbl[20] = '{1, 0, 2'b00, 1, 0, 2'b00, 0};
    tbl[21] = '{1, 1, 2'b10, 1, 0, 2'b00, 0};
    tbl[22] = '{1, 0, 2'b00, 1, 1, 2'b10, 0};

    bus.i_rx_lock    = 1'b0;
    bus.i_hdr_valid  = 1'b0;
    bus.i_hdr        = '0;
    bus.i_data_valid = 1'b0;
    bus.i_data       = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_valid", 64'(bus.o_blk_valid), 64'd0);
    check("init_data", bus.o_blk_data, 64'd0);
    check("init_hi_ber", 64'(bus.o_hi_ber), 64'd0);
    rst = 1'b0;

    // framing table
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].lock, tbl[i].hv, tbl[i].hdr, tbl[i].dv, $urandom);
      check($sformatf("tbl%0d_valid", i), 64'(bus.o_blk_valid), 64'(tbl[i].exp_v));
      if (tbl[i].exp_v) begin
        check($sformatf("tbl%0d_hdr", i), 64'(bus.o_blk_hdr), 64'(tbl[i].exp_hdr));
        check($sformatf("tbl%0d_err", i), 64'(bus.o_blk_hdr_err), 64'(tbl[i].exp_err));
      end
    end

    // reset mid-stream while a block is being presented
    send_block(2'b10);
    check("pre_reset_valid", 64'(bus.o_blk_valid), 64'd1);
    do_reset();
    send_block(2'b01);
    check("post_reset_valid", 64'(bus.o_blk_valid), 64'd1);
    check("post_reset_hdr", 64'(bus.o_blk_hdr), 64'd1);

    // known answer: all-zero payload scrambled from an all-ones seed; block 10 has a bad header
    tx_hist.delete();
    for (int i = 0; i < 58; i++) tx_hist.push_back(1'b1);
    for (int b = 0; b < 20; b++) begin
      h = (b == 10) ? 2'b11 : 2'b01;
      scramble64(64'd0, p);
      step(1'b1, 1'b1, h, 1'b1, p[31:0]);
      step(1'b1, 1'b0, 2'b00, 1'b1, p[63:32]);
      if (b >= 1) begin
        check($sformatf("kat%0d_valid", b), 64'(bus.o_blk_valid), 64'd1);
        check($sformatf("kat%0d_data", b), bus.o_blk_data, 64'd0);
        check($sformatf("kat%0d_hdr", b), 64'(bus.o_blk_hdr), 64'(h));
        check($sformatf("kat%0d_err", b), 64'(bus.o_blk_hdr_err), 64'(b == 10));
      end
    end

    // BER: window 0 with 16 bad headers, window 1 with 15
    do_reset();
    for (int b = 0; b < WIN; b++) send_block(b < THR ? 2'b11 : 2'b01);
    step(1'b1, 1'b0, 2'b00, 1'b0, 32'd0);
    check("ber_win0_hi", 64'(bus.o_hi_ber), 64'(BER_ON));
    for (int b = 0; b < WIN - 1; b++) send_block(b < THR - 1 ? 2'b00 : 2'b10);
    step(1'b1, 1'b0, 2'b00, 1'b0, 32'd0);
    check("ber_win1_before_wrap", 64'(bus.o_hi_ber), 64'(BER_ON));
    send_block(2'b01);
    step(1'b1, 1'b0, 2'b00, 1'b0, 32'd0);
    check("ber_win1_after_wrap", 64'(bus.o_hi_ber), 64'd0);

    // randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      bit lk, hv, dv;
      logic [1:0] hd;
      if (n == 1500) do_reset();
      lk = ($urandom % 60) != 0;
      hv = ($urandom % 10) < 4;
      dv = ($urandom % 8) != 0;
      hd = (($urandom % 8) == 0) ? (($urandom % 2) ? 2'b11 : 2'b00)
                                 : (($urandom % 2) ? 2'b10 : 2'b01);
      step(lk, hv, hd, dv, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_pcs_rx_descrambler.md
Name: eth_pcs_rx_descrambler

Overview:
- Downstream of the RX gearbox. Consumes its 32-bit data beats and 2-bit sync headers.
- Reassembles two beats plus the header into one 66b block (2b header, 64b payload) and self-synchronously descrambles the payload with G(x)=1+x^39+x^58.
- Flags invalid headers and presents blocks to the 64b/66b decoder.
- Optional BER monitor raises hi_ber per 802.3 clause 49.

Parameters:
- W_DATA, 32, gearbox beat width (cmn_params); the block supports 32 only.
- W_SYNC, 2, sync header width (eth_pcs_params).
- BER_WIN_BLKS, 19531, blocks per BER window (125 us at 156.25 Mblk/s).
- BER_THRESH, 16, invalid headers within one window that set hi_ber.

Ports:
- i_clk  in  1  PCS RX clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_rx_lock  in  1  block lock from block sync.
- i_hdr_valid  in  1  i_hdr is valid; marks the first beat of a block.
- i_hdr  in  W_SYNC  sync header, bit0 = first received.
- i_data_valid  in  1  i_data beat is valid.
- i_data  in  W_DATA  scrambled payload beat, bit0 = first received.
- o_blk_valid  out  1  one-cycle pulse: a block is present.
- o_blk_hdr  out  W_SYNC  header of the block.
- o_blk_data  out  2*W_DATA  descrambled payload; first beat is in [31:0].
- o_blk_hdr_err  out  1  qualified by o_blk_valid; header is 2'b00 or 2'b11.
- o_hi_ber  out  1  high bit-error-rate indication.

Behaviour:
- Reset (async, active-high): all outputs 0, descrambler state 0, half pointer = FIRST, BER counters 0.
- Descrambler math:
  - d_n = r_n ^ r_(n-39) ^ r_(n-58), where r is the received scrambled bit stream, processed bit0..bit31 within a beat.
  - State = last 58 received scrambled bits. It shifts only on i_data_valid=1, regardless of lock or half pointer.
  - The header is never descrambled and never enters the state.
  - All 32 bits of a beat are computed in one cycle.
- Half pointer FSM, states FIRST and SECOND; it advances only on i_data_valid=1:
  - FIRST to SECOND: beat with i_hdr_valid=1. Capture the header and the descrambled beat into the low half.
  - FIRST, beat with i_hdr_valid=0: the beat is dropped (state still updates). Stay in FIRST.
  - SECOND to FIRST: beat with i_hdr_valid=0. The beat goes into the high half, and the block is emitted next cycle.
  - SECOND, beat with i_hdr_valid=1 (resync): discard the partial block, treat this beat as a new low half, stay in SECOND. Nothing is emitted.
  - i_hdr_valid=1 with i_data_valid=0: ignored.
- Output timing:
  - o_blk_valid is registered and asserts 1 cycle after the second beat is accepted.
  - o_blk_hdr, o_blk_data and o_blk_hdr_err hold their values until the next block.
- Lock:
  - While i_rx_lock=0, the half pointer is forced to FIRST and o_blk_valid=0.
  - If lock drops mid-block, the partial block is discarded.
  - The first block is emitted only after lock is seen high at the first beat.
- Latency: the second beat at cycle N gives o_blk_valid at N+1.

Optional Feature:
- Macro: ETH_PCS_RX_BER_MON_EN.
- Defined:
  - Block counter counts emitted blocks from 0 to BER_WIN_BLKS-1, then wraps.
  - Error counter counts blocks with o_blk_hdr_err=1 and saturates at BER_THRESH.
  - o_hi_ber sets (registered) when the error counter reaches BER_THRESH inside a window.
  - At window wrap: if errors < BER_THRESH, o_hi_ber clears. Both counters restart.
  - If an error coincides with the wrap, the error counts in the new window.
  - i_rx_lock=0 clears both counters and o_hi_ber.
- Undefined: o_hi_ber is tied 0 and no counters are synthesised.

Test Plan:
- Reset check: assert i_reset mid-stream -> all outputs 0 immediately. After release, the first block appears 1 cycle after its second beat.
- Descrambler, known answer: scramble a 64-bit all-zero payload for 20 blocks with seed 58'h3_FFFF_FFFF_FFFF_FF. Feed with hdr 2'b01 -> from block 2 onward o_blk_data=64'h0, o_blk_hdr=2'b01, o_blk_hdr_err=0.
- Header error: hdr 2'b11 on one block -> o_blk_hdr_err=1 for that block only. Payload is still descrambled correctly.
- Lock drop: drop i_rx_lock between beat 1 and beat 2 -> no o_blk_valid for that block. The next block after relock is emitted normally.
- Resync: two consecutive beats with i_hdr_valid=1 -> the first partial block is discarded, and the block completes with the second beat as its low half.
- BER (macro defined; BER_WIN_BLKS=64, BER_THRESH=16):
  - 16 bad headers in window 0 -> o_hi_ber=1.
  - Window 1 with 15 bad headers -> o_hi_ber=0 after the wrap.
  - Macro undefined -> o_hi_ber stays 0 throughout.
